// File: rtl/memwb_skid_reg.sv
// memwb_skid_reg
//   MEM/WB pipeline stage built as a 2-entry skid buffer. The memory stage
//   pushes beats with in_valid/in_ready and writeback pops them with
//   out_valid/out_ready. in_ready is derived only from registered state, so
//   writeback back-pressure (out_ready) never reaches the memory stage
//   combinationally.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous squash of all buffered beats
//   in_valid/in_ready   upstream handshake
//   *_in                beat fields (RegWrite, ret, mem_to_reg, rd, mem data,
//                       ALU result, HALT)
//   out_valid/out_ready downstream handshake on the head entry
//   *_out               head entry fields; RegWrite/ret/HALT gated by out_valid
//   wb_data_out         mem_to_reg_out ? mem_read_data_out : alu_result_out
//   halted              sticky, set once a HALT beat has been consumed
//   occupancy           number of buffered beats (0..2)
module memwb_skid_reg #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              RegWrite_in,
  input  logic              ret_in,
  input  logic              mem_to_reg_in,
  input  logic [REG_AW-1:0] reg_rd_in,
  input  logic [DATA_W-1:0] mem_read_data_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic              HALT_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              RegWrite_out,
  output logic              ret_out,
  output logic              mem_to_reg_out,
  output logic [REG_AW-1:0] reg_rd_out,
  output logic [DATA_W-1:0] mem_read_data_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] wb_data_out,
  output logic              HALT_out,
  output logic              halted,
  output logic [1:0]        occupancy
);

  typedef struct packed {
    logic              rw;
    logic              ret;
    logic              m2r;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] mem;
    logic [DATA_W-1:0] alu;
    logic              halt;
  } beat_t;

  beat_t h_q, h_d, s_q, s_d, in_beat;
  logic  hv_q, hv_d, sv_q, sv_d;
  logic  pend_q, pend_d, halted_q, halted_d;
  logic  accept, consume;

  assign in_beat = '{rw: RegWrite_in, ret: ret_in, m2r: mem_to_reg_in,
                     rd: reg_rd_in, mem: mem_read_data_in,
                     alu: alu_result_in, halt: HALT_in};

  // Registered state only: no path from out_ready.
  assign in_ready = !sv_q && !pend_q && !halted_q;
  assign accept   = in_valid && in_ready;
  assign consume  = hv_q && out_ready;

  always_comb begin
    h_d      = h_q;
    s_d      = s_q;
    hv_d     = hv_q;
    sv_d     = sv_q;
    pend_d   = pend_q;
    halted_d = halted_q;

    // A HALT beat can't be accepted while another is pending, so the
    // clear and set below never collide on the same beat.
    if (consume && h_q.halt) begin
      halted_d = 1'b1;
      pend_d   = 1'b0;
    end
    if (accept && in_beat.halt) pend_d = 1'b1;

    // S is only ever valid while H is valid.
    if (!hv_q) begin
      if (accept) begin
        h_d  = in_beat;
        hv_d = 1'b1;
      end
    end else if (!consume) begin
      if (accept) begin
        s_d  = in_beat;
        sv_d = 1'b1;
      end
    end else if (sv_q) begin
      h_d  = s_q;            // in_ready is 0 here, so no accept competes
      sv_d = 1'b0;
    end else if (accept) begin
      h_d  = in_beat;
    end else begin
      hv_d = 1'b0;
    end

    // Flush wins over any accept but leaves a same-cycle consume (and the
    // halted update above) intact. Stale fields are harmless once invalid.
    if (flush) begin
      hv_d   = 1'b0;
      sv_d   = 1'b0;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q      <= '0;
      s_q      <= '0;
      hv_q     <= 1'b0;
      sv_q     <= 1'b0;
      pend_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      h_q      <= h_d;
      s_q      <= s_d;
      hv_q     <= hv_d;
      sv_q     <= sv_d;
      pend_q   <= pend_d;
      halted_q <= halted_d;
    end
  end

  assign out_valid         = hv_q;
  assign RegWrite_out      = h_q.rw   & hv_q;
  assign ret_out           = h_q.ret  & hv_q;
  assign HALT_out          = h_q.halt & hv_q;
  assign mem_to_reg_out    = h_q.m2r;
  assign reg_rd_out        = h_q.rd;
  assign mem_read_data_out = h_q.mem;
  assign alu_result_out    = h_q.alu;
  assign wb_data_out       = h_q.m2r ? h_q.mem : h_q.alu;
  assign halted            = halted_q;
  assign occupancy         = {1'b0, hv_q} + {1'b0, sv_q};

endmodule

// File: tb/tb_memwb_skid_reg.sv
// Bench for memwb_skid_reg: a queue-based reference model tracks accepted
// beats; a negedge monitor compares the DUT head/occupancy/ready against it.
module tb_memwb_skid_reg;
  localparam int DATA_W = 16;
  localparam int REG_AW = 4;

  typedef struct packed {
    logic              rw;
    logic              ret;
    logic              m2r;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] mem;
    logic [DATA_W-1:0] alu;
    logic              halt;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  beat_t din = '0;
  logic in_ready, out_valid, RegWrite_out, ret_out, mem_to_reg_out, HALT_out, halted;
  logic [REG_AW-1:0] reg_rd_out;
  logic [DATA_W-1:0] mem_read_data_out, alu_result_out, wb_data_out;
  logic [1:0] occupancy;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // reference model state
  beat_t q[$];
  bit pend_m = 1'b0, halted_m = 1'b0;

  always #5 clk = ~clk;

  memwb_skid_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .RegWrite_in(din.rw), .ret_in(din.ret), .mem_to_reg_in(din.m2r), .reg_rd_in(din.rd),
    .mem_read_data_in(din.mem), .alu_result_in(din.alu), .HALT_in(din.halt),
    .out_valid(out_valid), .out_ready(out_ready), .RegWrite_out(RegWrite_out),
    .ret_out(ret_out), .mem_to_reg_out(mem_to_reg_out), .reg_rd_out(reg_rd_out),
    .mem_read_data_out(mem_read_data_out), .alu_result_out(alu_result_out),
    .wb_data_out(wb_data_out), .HALT_out(HALT_out), .halted(halted), .occupancy(occupancy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_rdy();
    return (q.size() < 2) && !pend_m && !halted_m;
  endfunction

  // Reference model: a FIFO of at most two beats.
  initial begin
    beat_t f;
    bit acc, con;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        pend_m = 1'b0;
        halted_m = 1'b0;
      end else begin
        acc = in_valid && m_rdy();
        con = out_ready && (q.size() > 0);
        if (con) begin
          f = q.pop_front();
          if (f.halt) begin
            halted_m = 1'b1;
            pend_m = 1'b0;
          end
        end
        if (flush) begin
          q.delete();
          pend_m = 1'b0;
        end else if (acc) begin
          q.push_back(din);
          if (din.halt) pend_m = 1'b1;
        end
      end
    end
  end

  // Monitor: compare whatever the DUT presents against the model.
  initial begin
    beat_t e;
    logic [63:0] act, exp;
    forever begin
      @(negedge clk);
      if (chk_en && rst_n) begin
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("occupancy", 64'(occupancy), 64'(q.size()));
        chk("in_ready", 64'(in_ready), 64'(m_rdy()));
        chk("halted", 64'(halted), 64'(halted_m));
        act = 64'({RegWrite_out, ret_out, HALT_out});
        if (q.size() > 0) begin
          e = q[0];
          chk("gated", act, 64'({e.rw, e.ret, e.halt}));
          act = 64'({mem_to_reg_out, reg_rd_out, mem_read_data_out, alu_result_out, wb_data_out});
          exp = 64'({e.m2r, e.rd, e.mem, e.alu, (e.m2r ? e.mem : e.alu)});
          chk("head", act, exp);
        end else begin
          chk("gated_idle", act, 64'd0);
        end
      end
    end
  end

  task automatic cyc(input logic v, input beat_t b, input logic ordy, input logic fl);
    in_valid = v;
    din = b;
    out_ready = ordy;
    flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic beat_t mk(input int rd, input int alu, input int mem, input bit m2r, input bit halt);
    beat_t b;
    b.rw = 1'b1;
    b.ret = 1'b0;
    b.m2r = m2r;
    b.rd = REG_AW'(rd);
    b.alu = DATA_W'(alu);
    b.mem = DATA_W'(mem);
    b.halt = halt;
    return b;
  endfunction

  function automatic beat_t rnd_beat();
    beat_t b;
    b.rw = 1'($urandom);
    b.ret = 1'($urandom);
    b.m2r = 1'($urandom);
    b.rd = REG_AW'($urandom);
    b.mem = DATA_W'($urandom);
    b.alu = DATA_W'($urandom);
    b.halt = ($urandom_range(0, 39) == 0);
    return b;
  endfunction

  initial begin
    beat_t z;
    z = '0;
    do_reset();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_wb", 64'(wb_data_out), 64'd0);
    chk_en = 1'b1;

    // Streaming
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b1, mk(k, 'h11 * k, 0, 1'b0, 1'b0), 1'b1, 1'b0);
      chk("stream_occ", 64'(occupancy), 64'd1);
      chk("stream_wb", 64'(wb_data_out), 64'('h11 * k));
    end
    cyc(1'b0, z, 1'b1, 1'b0);

    // Back-pressure
    cyc(1'b1, mk(5, 'h55, 0, 1'b0, 1'b0), 1'b0, 1'b0);
    cyc(1'b1, mk(6, 'h66, 0, 1'b0, 1'b0), 1'b0, 1'b0);
    chk("bp_occ", 64'(occupancy), 64'd2);
    chk("bp_rdy", 64'(in_ready), 64'd0);
    chk("bp_headA", 64'(reg_rd_out), 64'd5);
    cyc(1'b0, z, 1'b1, 1'b0);
    chk("bp_headB", 64'(reg_rd_out), 64'd6);
    cyc(1'b0, z, 1'b1, 1'b0);
    chk("bp_drained", 64'(occupancy), 64'd0);

    // Load select
    cyc(1'b1, mk(3, 'h1234, 'hBEEF, 1'b1, 1'b0), 1'b0, 1'b0);
    chk("sel_mem", 64'(wb_data_out), 64'hBEEF);
    cyc(1'b1, mk(3, 'h1234, 'hBEEF, 1'b0, 1'b0), 1'b1, 1'b0);
    chk("sel_alu", 64'(wb_data_out), 64'h1234);
    cyc(1'b0, z, 1'b1, 1'b0);

    // Flush with a full buffer and a same-cycle incoming beat
    cyc(1'b1, mk(7, 'h77, 0, 1'b0, 1'b0), 1'b0, 1'b0);
    cyc(1'b1, mk(8, 'h88, 0, 1'b0, 1'b0), 1'b0, 1'b0);
    chk("fl_pre_occ", 64'(occupancy), 64'd2);
    cyc(1'b1, mk(9, 'h99, 0, 1'b0, 1'b0), 1'b0, 1'b1);
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_occ", 64'(occupancy), 64'd0);
    chk("fl_rw", 64'(RegWrite_out), 64'd0);
    cyc(1'b0, z, 1'b1, 1'b0);
    cyc(1'b0, z, 1'b1, 1'b0);

    // Halt
    cyc(1'b1, mk(10, 'hAA, 0, 1'b0, 1'b1), 1'b0, 1'b0);
    chk("halt_rdy", 64'(in_ready), 64'd0);
    chk("halt_out", 64'(HALT_out), 64'd1);
    cyc(1'b1, mk(11, 'hBB, 0, 1'b0, 1'b0), 1'b0, 1'b0);
    chk("halt_occ", 64'(occupancy), 64'd1);
    cyc(1'b1, mk(11, 'hBB, 0, 1'b0, 1'b0), 1'b1, 1'b0);
    chk("halt_set", 64'(halted), 64'd1);
    chk("halt_out_off", 64'(HALT_out), 64'd0);
    for (int k = 0; k < 3; k++) cyc(1'b1, mk(12, 'hCC, 0, 1'b0, 1'b0), 1'b1, 1'b0);
    chk("halt_sticky", 64'(halted), 64'd1);
    chk("halt_block", 64'(occupancy), 64'd0);

    // Halt flushed before consumption
    do_reset();
    cyc(1'b1, mk(10, 'hAA, 0, 1'b0, 1'b1), 1'b0, 1'b0);
    cyc(1'b0, z, 1'b0, 1'b1);
    chk("hf_halted", 64'(halted), 64'd0);
    chk("hf_rdy", 64'(in_ready), 64'd1);
    cyc(1'b1, mk(13, 'hDD, 0, 1'b0, 1'b0), 1'b0, 1'b0);
    chk("hf_accept", 64'(out_valid), 64'd1);

    // Async reset with two beats buffered
    cyc(1'b1, mk(14, 'hEE, 0, 1'b0, 1'b0), 1'b0, 1'b0);
    chk("ar_pre_occ", 64'(occupancy), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(out_valid), 64'd0);
    chk("ar_occ", 64'(occupancy), 64'd0);
    chk("ar_wb", 64'(wb_data_out), 64'd0);
    do_reset();
    chk("ar_rdy", 64'(in_ready), 64'd1);

    // Randomized traffic against the model
    for (int blk = 0; blk < 4; blk++) begin
      do_reset();
      for (int k = 0; k < 300; k++)
        cyc(($urandom_range(0, 9) < 7), rnd_beat(), ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 24) == 0));
    end
    cyc(1'b0, z, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
